// File: rtl/arb_rr.sv
// Round-robin grant for N requesters: the first asserted request at or above ptr,
// wrapping from N-1 back to 0. Purely combinational.
module arb_rr #(
  parameter int N  = 16,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_iso;

  // The low copy holds only requests at or above ptr. The high copy holds all of
  // them, and it catches the wrap when nothing is set at or above ptr. Isolating the
  // lowest set bit of the 2N-bit word keeps the carry chain at 2N.
  assign w_mask = ~((ONE_N << ptr) - ONE_N);
  assign w_dbl  = {req, req & w_mask};
  assign w_iso  = w_dbl & (~w_dbl + ONE_2N);
  assign grant  = w_iso[N-1:0] | w_iso[2*N-1:N];

endmodule

// File: rtl/muxhot_arbiter.sv
// Round-robin arbiter with a one-hot AND-OR data mux and a registered output stage.
// It shares one DW-bit valid/ready channel among N requesters.
module muxhot_arbiter #(
  parameter int DW = 64,
  parameter int N  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out,
  input  logic            out_ready,
  output logic [N-1:0]    out_grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic          r_out_valid;
  logic [DW-1:0] r_out;
  logic [N-1:0]  r_out_grant;

  logic          w_load;
  logic [N-1:0]  w_grant;
  logic [DW-1:0] w_data;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_ptr_nxt;

  arb_rr #(.N(N), .PW(PW)) u_arb (
    .req   (in_valid),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  assign w_load   = ~r_out_valid | out_ready;
  assign in_ready = w_grant & {N{w_load}};

  // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
  always_comb begin
    w_data = '0;
    w_idx  = '0;
    for (int i = 0; i < N; i++) begin
      w_data = w_data | ({DW{w_grant[i]}} & in[i*DW +: DW]);
      if (w_grant[i]) w_idx = w_idx | PW'(i);
    end
  end

  assign w_ptr_nxt = (w_idx == PW'(N - 1)) ? '0 : w_idx + PW'(1);

  // NOTE: sequential state uses non-blocking assignments only. The data register is
  // reset as well, so out reads 0 right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_grant <= '0;
    end else if (w_load) begin
      if (|w_grant) begin
        r_out       <= w_data;
        r_out_valid <= 1'b1;
        r_out_grant <= w_grant;
        r_ptr       <= w_ptr_nxt;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_grant = r_out_grant;

endmodule

// File: tb/tb_muxhot_arbiter.sv
// Self-checking bench for muxhot_arbiter (N=4, DW=8): a round-robin reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_muxhot_arbiter;

  localparam int DW = 8;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out;
  logic            out_ready;
  logic [N-1:0]    out_grant;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int            m_ptr   = 0;
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_out   = '0;
  logic [N-1:0]  m_grant = '0;

  muxhot_arbiter #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (out),
    .out_ready (out_ready),
    .out_grant (out_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle's inputs on the falling edge and compares the DUT with the
  // model. It then advances the model across the rising edge.
  task automatic cycle(input bit r, input logic [N-1:0] v, input logic [N*DW-1:0] d,
                       input bit rdy);
    int            gidx;
    bit            load;
    logic [N-1:0]  exp_ready;
    @(negedge clk);
    rst = r; in_valid = v; in = d; out_ready = rdy;
    #1;
    load = !m_valid || rdy;
    gidx = -1;
    for (int k = 0; k < N; k++) begin
      if (gidx < 0 && v[(m_ptr + k) % N]) gidx = (m_ptr + k) % N;
    end
    exp_ready = (load && gidx >= 0) ? N'(1) << gidx : '0;
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check("out", 64'(out), 64'(m_out));
      check("out_grant", 64'(out_grant), 64'(m_grant));
    end
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_out = '0; m_grant = '0; m_ptr = 0;
    end else if (load) begin
      if (gidx >= 0) begin
        m_out   = d[gidx*DW +: DW];
        m_valid = 1'b1;
        m_grant = N'(1) << gidx;
        m_ptr   = (gidx + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  logic [N*DW-1:0] d_inc;
  logic [N*DW-1:0] d_aa;

  initial begin
    rst = 1'b1; in_valid = '0; in = '0; out_ready = 1'b1;
    d_inc = {8'd4, 8'd3, 8'd2, 8'd1};
    d_aa  = {8'h44, 8'h33, 8'h22, 8'hAA};

    // Reset followed by idle cycles.
    cycle(1, '0, '0, 1);
    check("rst_out", 64'(out), 64'h0);
    check("rst_grant", 64'(out_grant), 64'h0);
    for (int c = 0; c < 5; c++) begin
      cycle(0, '0, '0, 1);
      check("idle_valid", 64'(out_valid), 64'h0);
      check("idle_ready", 64'(in_ready), 64'h0);
    end

    // All requesters valid: output data and grant rotate in order.
    begin
      logic [DW-1:0] exp_o [6];
      logic [N-1:0]  exp_g [6];
      exp_o = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2};
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      for (int c = 0; c < 6; c++) begin
        cycle(0, 4'b1111, d_inc, 1);
        check("rot_out", 64'(out), 64'(exp_o[c]));
        check("rot_grant", 64'(out_grant), 64'(exp_g[c]));
      end
    end

    // Requesters 1 and 3 only, starting from a reset pointer.
    cycle(1, '0, '0, 1);
    begin
      logic [N-1:0] exp_g [3];
      exp_g = '{4'b0010, 4'b1000, 4'b0010};
      for (int c = 0; c < 3; c++) begin
        cycle(0, 4'b1010, d_inc, 1);
        check("sparse_grant", 64'(out_grant), 64'(exp_g[c]));
      end
    end

    // Stall with 0xAA held, then pop and load in the same cycle.
    cycle(1, '0, '0, 1);
    cycle(0, 4'b0001, d_aa, 1);
    check("stall_load", 64'(out), 64'hAA);
    for (int c = 0; c < 3; c++) begin
      cycle(0, 4'b1110, d_aa, 0);
      check("stall_out", 64'(out), 64'hAA);
      check("stall_ready", 64'(in_ready), 64'h0);
    end
    cycle(0, 4'b1110, d_aa, 1);
    check("pop_load_grant", 64'(out_grant), 64'b0010);
    check("pop_load_out", 64'(out), 64'h22);

    // Pointer wrap: grant 3, then 0, then the pointer sits at 1.
    cycle(1, '0, '0, 1);
    cycle(0, 4'b1000, d_inc, 1);
    check("wrap_g3", 64'(out_grant), 64'b1000);
    cycle(0, 4'b0001, d_inc, 1);
    check("wrap_g0", 64'(out_grant), 64'b0001);
    cycle(0, 4'b1111, d_inc, 1);
    check("wrap_ptr1", 64'(out_grant), 64'b0010);

    // Reset while the stage is stalled with valid data.
    cycle(0, 4'b0100, d_inc, 0);
    cycle(0, 4'b0000, d_inc, 0);
    cycle(1, 4'b0000, d_inc, 0);
    check("rst_mid_valid", 64'(out_valid), 64'h0);
    check("rst_mid_grant", 64'(out_grant), 64'h0);
    cycle(0, 4'b1100, d_inc, 1);
    check("rst_first_grant", 64'(out_grant), 64'b0100);

    // Randomized traffic with occasional stalls and resets.
    for (int c = 0; c < 400; c++) begin
      cycle(($urandom_range(0, 49) == 0), N'($urandom), $urandom,
            ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
